// File: rtl/window_arb_pkg.sv
// rtl/window_arb_pkg.sv - shared types and length helpers for the window bus arbiter
package window_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        BURST = 2'd2,
        CLOSE = 2'd3
    } win_state_t;

    // Longest burst that still leaves GUARD idle cycles on both sides of the window
    function automatic int unsigned lmax_of(input int unsigned win_len, input int unsigned guard);
        return win_len - 2 * guard;
    endfunction

    // A zero request still gets one bus cycle; oversize requests are cut to the window
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned lmax);
        if (len == 0)
            return 1;
        else if (len > lmax)
            return lmax;
        else
            return len;
    endfunction

endpackage

// File: rtl/window_bus_arbiter_rr_arbiter.sv
// rtl/window_bus_arbiter_rr_arbiter.sv - round-robin pick with pointer advanced past the last winner
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] won,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]  ptr;
    logic [PW-1:0]  ptr_next;
    logic [2*N-1:0] req_rot2;
    logic [2*N-1:0] gnt_rot2;
    logic [N-1:0]   rot;
    logic [N-1:0]   pick;

    // Rotate so the pointer position is bit 0, take the lowest set bit, rotate back
    assign req_rot2 = {req, req} >> ptr;
    assign rot      = req_rot2[N-1:0];
    assign pick     = rot & (~rot + {{(N-1){1'b0}}, 1'b1});
    assign gnt_rot2 = {pick, pick} << ptr;
    assign gnt      = gnt_rot2[2*N-1:N];

    // Next search starts one past the requester that just completed its window
    always_comb begin
        ptr_next = ptr;
        for (int i = 0; i < N; i++) begin
            if (won[i])
                ptr_next = PW'((i + 1) % N);
        end
    end

    // Pointer moves only on a completed window
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (advance)
            ptr <= ptr_next;
    end

endmodule

// File: rtl/window_bus_arbiter.sv
// rtl/window_bus_arbiter.sv - train-window bus scheduler; WINDOW_ASSERT_EN adds embedded assertions
module window_bus_arbiter
    import window_arb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int WIN_LEN = 8,
    parameter int GUARD   = 1,
    parameter int LEN_W   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   transport,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*LEN_W-1:0] burst_len,
    output logic                   train,
    output logic                   bus,
    output logic [N_REQ-1:0]       gnt,
    output logic                   done,
    output logic                   abort
);

    localparam int unsigned     LMAX      = lmax_of(WIN_LEN, GUARD);
    localparam int              CW        = $clog2(WIN_LEN + 1);
    localparam logic [CW-1:0]   WIN_END   = CW'(WIN_LEN);
    localparam logic [CW-1:0]   GUARD_END = CW'(GUARD);

    win_state_t       state;
    win_state_t       state_next;
    logic [CW-1:0]    win_cnt;
    logic [CW-1:0]    len_q;
    logic [CW-1:0]    burst_end;
    logic [N_REQ-1:0] win_q;
    logic [N_REQ-1:0] rr_gnt;
    logic [LEN_W-1:0] sel_len;
    logic             start;
    logic             last;
    logic             kill;

    assign start     = (state == IDLE) && transport && (|req);
    assign last      = (win_cnt == WIN_END);
    assign kill      = (state != IDLE) && !transport && !last;
    assign burst_end = GUARD_END + len_q;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .won     (win_q),
        .advance (done),
        .gnt     (rr_gnt)
    );

    // Burst length of whichever requester the arbiter is currently offering
    always_comb begin
        sel_len = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (rr_gnt[i])
                sel_len = burst_len[i*LEN_W +: LEN_W];
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Window sequencing; transport loss ends any active phase at once
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = OPEN;
            OPEN:    if (kill) state_next = IDLE;
                     else if (win_cnt == GUARD_END) state_next = BURST;
            BURST:   if (kill) state_next = IDLE;
                     else if (win_cnt == burst_end) state_next = CLOSE;
            CLOSE:   if (kill || last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Window outputs decoded from state; grant is only visible while the train runs
    always_comb begin
        train = (state != IDLE);
        bus   = (state == BURST);
        done  = (state == CLOSE) && last;
        gnt   = train ? win_q : '0;
    end

    // Window counter, latched winner and length, registered abort pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt <= '0;
            len_q   <= '0;
            win_q   <= '0;
            abort   <= 1'b0;
        end else begin
            abort <= kill;
            if (start) begin
                win_cnt <= CW'(1);
                len_q   <= CW'(clamp_len(32'(sel_len), LMAX));
                win_q   <= rr_gnt;
            end else if (state_next == IDLE) begin
                win_cnt <= '0;
            end else begin
                win_cnt <= win_cnt + CW'(1);
            end
        end
    end

`ifdef WINDOW_ASSERT_EN
    int unsigned train_run;

    // Length of the current train run, for the per-window length check
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            train_run <= 0;
        else
            train_run <= train ? train_run + 1 : 0;
    end

    a_transport_throughout: assert property (@(posedge clk) disable iff (rst)
        (train && !done && !transport) |=> (abort && !train))
        else $error("%0t transport fell inside a window without abort", $time);

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt))
        else $error("%0t gnt not one-hot", $time);

    a_bus_within_train: assert property (@(posedge clk) disable iff (rst) bus |-> train)
        else $error("%0t bus outside train", $time);

    a_done_abort_excl: assert property (@(posedge clk) disable iff (rst) !(done && abort))
        else $error("%0t done and abort together", $time);

    a_train_len: assert property (@(posedge clk) disable iff (rst) done |-> (train_run + 1 == WIN_LEN))
        else $error("%0t train length wrong at done", $time);
`endif

endmodule

// File: tb/tb_window_bus_arbiter.sv
// tb/tb_window_bus_arbiter.sv - scoreboard bench for window_bus_arbiter
module tb_window_bus_arbiter;

    localparam int N_REQ   = 2;
    localparam int WIN_LEN = 8;
    localparam int GUARD   = 1;
    localparam int LEN_W   = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   transport;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*LEN_W-1:0] burst_len;
    logic                   train;
    logic                   bus;
    logic [N_REQ-1:0]       gnt;
    logic                   done;
    logic                   abort;

    logic [5:0] obs;
    logic [5:0] e;
    logic [5:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    assign obs = {train, bus, gnt, done, abort};

    window_bus_arbiter #(.N_REQ(N_REQ), .WIN_LEN(WIN_LEN), .GUARD(GUARD), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .transport (transport),
        .req       (req),
        .burst_len (burst_len),
        .train     (train),
        .bus       (bus),
        .gnt       (gnt),
        .done      (done),
        .abort     (abort)
    );

    always #5 clk = ~clk;

    // Expected {train,bus,gnt,done,abort} for the first n cycles of a window with effective length l
    task automatic push_window(input logic [1:0] g, input int l, input int n);
        for (int k = 1; k <= n; k++)
            exp_q.push_back({1'b1, (k >= GUARD + 1 && k <= GUARD + l), g, (k == WIN_LEN), 1'b0});
    endtask

    task automatic push_idle(input int n, input logic ab);
        for (int k = 0; k < n; k++)
            exp_q.push_back({5'b00000, (k == 0) ? ab : 1'b0});
    endtask

    task automatic apply_reset();
        rst = 1'b1; transport = 1'b0; req = '0; burst_len = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; transport = 1'b1; req = 2'b11; burst_len = {4'd3, 4'd3};
        @(negedge clk);
        n_checks++;
        if (obs !== 6'b0) begin n_fail++; $display("FAIL reset_held: got %b expected %b", obs, 6'b0); end
        transport = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs !== 6'b0) begin n_fail++; $display("FAIL reset_released: got %b expected %b", obs, 6'b0); end
    endtask

    task automatic test_basic();
        apply_reset();
        transport = 1'b1; req = 2'b01; burst_len = {4'd0, 4'd3};
        push_window(2'b01, 3, 8); push_idle(1, 1'b0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk); e = exp_q.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL basic cycle %0d: got %b expected %b", i, obs, e); end
            if (i == 0) req = 2'b00;
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        transport = 1'b1; req = 2'b11; burst_len = {4'd2, 4'd2};
        push_window(2'b01, 2, 8); push_idle(1, 1'b0);
        push_window(2'b10, 2, 8); push_idle(1, 1'b0);
        push_window(2'b01, 2, 8); push_idle(1, 1'b0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk); e = exp_q.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL round_robin cycle %0d: got %b expected %b", i, obs, e); end
            if (i == 25) req = 2'b00;
        end
    endtask

    task automatic test_clamp();
        apply_reset();
        transport = 1'b1; req = 2'b01; burst_len = {4'd0, 4'd0};
        push_window(2'b01, 1, 8); push_idle(1, 1'b0);
        push_window(2'b01, 6, 8); push_idle(1, 1'b0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk); e = exp_q.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL clamp cycle %0d: got %b expected %b", i, obs, e); end
            if (i == 8) burst_len = {4'd0, 4'd15};
            if (i == 16) req = 2'b00;
        end
    endtask

    task automatic test_abort();
        apply_reset();
        transport = 1'b1; req = 2'b11; burst_len = {4'd3, 4'd3};
        push_window(2'b01, 3, 8); push_idle(1, 1'b0);
        push_window(2'b10, 3, 3); push_idle(2, 1'b1);
        push_window(2'b10, 3, 8); push_idle(1, 1'b0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk); e = exp_q.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL abort cycle %0d: got %b expected %b", i, obs, e); end
            if (i == 11) transport = 1'b0;
            if (i == 13) transport = 1'b1;
            if (i == 21) req = 2'b00;
        end
    endtask

    task automatic test_transport_gate();
        apply_reset();
        transport = 1'b0; req = 2'b11; burst_len = {4'd3, 4'd4};
        push_idle(10, 1'b0);
        push_window(2'b01, 4, 8); push_idle(1, 1'b0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk); e = exp_q.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL transport_gate cycle %0d: got %b expected %b", i, obs, e); end
            if (i == 9) transport = 1'b1;
            if (i == 17) req = 2'b00;
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        transport = 1'b1; req = 2'b01; burst_len = {4'd2, 4'd2};
        push_window(2'b01, 2, 6);
        push_window(2'b10, 2, 8); push_idle(1, 1'b0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk); e = exp_q.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL async_reset cycle %0d: got %b expected %b", i, obs, e); end
            if (i == 5) begin
                #2 rst = 1'b1;
                #1 n_checks++;
                if (obs !== 6'b0) begin n_fail++; $display("FAIL async_reset_immediate: got %b expected %b", obs, 6'b0); end
                @(negedge clk);
                rst = 1'b0; req = 2'b10;
            end
            if (i == 13) req = 2'b00;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_clamp();
        test_abort();
        test_transport_gate();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/window_bus_arbiter.md
Name: window_bus_arbiter

Overview:
Schedules a shared bus among N requesters using fixed-length "train" windows. One winner per window gets a bus burst nested strictly inside the window, with guard cycles on both sides. The whole transaction is qualified by a master enable, "transport", which must stay high for the entire window. The block produces the transport/bus/train relationship that the team's "transport throughout (bus within train)" assertions check, and it sits between the requesters and the shared bus.

Parameters:
N_REQ, 2, number of requesters (2..8)
WIN_LEN, 8, train window length in cycles (>= 2*GUARD+1)
GUARD, 1, idle cycles inside the window before and after the burst (>= 1)
LEN_W, 4, width of each requested burst length

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  reset, asynchronous and active-high
transport  in  1  master enable; must be held throughout each window
req  in  N_REQ  request vector, level-sensitive
burst_len  in  N_REQ*LEN_W  packed burst lengths; slice i belongs to req[i]
train  out  1  window active
bus  out  1  bus burst active; always within train
gnt  out  N_REQ  one-hot grant, held for the whole window
done  out  1  one-cycle pulse on the last train cycle of a completed window
abort  out  1  one-cycle pulse when a window is killed by transport falling

Behaviour:
- Reset: all outputs are 0, state is IDLE, rr pointer is 0, counters are 0. Reset applies immediately at any point, including mid-window; train, bus and gnt drop without a done or abort pulse.
- States:
  - IDLE: if transport & |req at a clock edge, arbitrate and go to OPEN.
  - OPEN: train=1 for GUARD cycles, then go to BURST.
  - BURST: bus=1 for L cycles, then go to CLOSE.
  - CLOSE: train=1 until the window count reaches WIN_LEN, then go to IDLE.
- Timing: with request sampled at t0, train is high t1..t(WIN_LEN) and bus is high t(1+GUARD)..t(GUARD+L). done pulses at t(WIN_LEN). train is low for at least 1 cycle between windows.
- Arbitration: round-robin. Search starts at the index after the last completed winner. gnt and L are latched at arbitration; later changes to req or burst_len are ignored until IDLE.
- Length rules:
  - L = burst_len slice of the winner.
  - L=0 is treated as 1.
  - L above LMAX = WIN_LEN-2*GUARD is clamped to LMAX.
  - Arithmetic is unsigned, in a counter of width $clog2(WIN_LEN+1).
- Abort:
  - transport low in OPEN, BURST or CLOSE moves the block to IDLE next cycle.
  - train, bus and gnt go 0 that cycle; abort pulses once; done does not pulse.
  - The rr pointer is not advanced, so the same requester wins next.
- A requester that deasserts req mid-window does not end the window; the window completes normally.
- transport low in IDLE means no arbitration; req is ignored.
- Simultaneous last window cycle and new request: the block returns to IDLE first, so a new window never starts back-to-back.

Optional Feature:
WINDOW_ASSERT_EN: when defined, the block compiles embedded concurrent assertions on posedge clk, disabled during rst:
- transport throughout (bus within train), checked for each window
- $onehot0(gnt)
- bus implies train
- done and abort never asserted together
- train high count equals WIN_LEN, checked on each done

Failures report via $error with $time. When not defined, no assertions are compiled and RTL behaviour is identical.

Decomposition:
- Package window_arb_pkg holds:
  - state enum typedef (IDLE, OPEN, BURST, CLOSE)
  - function clamp_len(len, lmax) implementing the L rules
  - localparam LMAX derivation helper
- Sub-module rr_arbiter (parameter N): inputs req and advance, output one-hot gnt; pointer update on advance.

Test Plan:
1. transport=1, req=01, len0=3, defaults; request at t0 -> train t1..t8, bus t2..t4, gnt=01, done at t8.
2. req=11 held over 3 windows, all len=2 -> gnt sequence 01, 10, 01; train low exactly 1 cycle between windows.
3. len0=0 then len0=15 -> bus high 1 cycle, then 6 cycles (LMAX=6); train still 8 cycles.
4. transport drops during BURST at t3 -> train, bus and gnt 0 at t4, abort pulse, no done; next window grants the same requester.
5. transport=0, req=11 for 10 cycles -> train stays 0; raise transport -> window starts the next cycle.
6. rst asserted asynchronously mid-CLOSE -> all outputs 0 immediately; after release with req=10 -> gnt=10 (pointer reset to 0).
